// File: rtl/rv32i_alu_arbiter.sv
// Two-requester round-robin front end for a single combinational RV32I ALU, with a one-entry response register.
// Optional saturating grant/conflict counters are built when RV32I_ALU_ARB_STATS_EN is defined.

module rv32i_alu (
  input  logic [3:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] result
);

  // RV32I integer ALU; shifts take their amount from b[4:0] only
  always_comb begin
    result = 32'd0;
    case (op)
      4'b0000: result = a + b;
      4'b0001: result = a << b[4:0];
      4'b0010: result = {31'd0, ($signed(a) < $signed(b))};
      4'b0011: result = {31'd0, (a < b)};
      4'b0100: result = a ^ b;
      4'b0101: result = a >> b[4:0];
      4'b0110: result = a | b;
      4'b0111: result = a & b;
      4'b1000: result = a - b;
      4'b1101: result = $unsigned($signed(a) >>> b[4:0]);
      default: result = 32'd0;
    endcase
  end

endmodule

module rv32i_alu_arbiter #(
  parameter int TAG_W  = 4,
  parameter int STAT_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [3:0]        req0_op,
  input  logic [31:0]       req0_a,
  input  logic [31:0]       req0_b,
  input  logic [TAG_W-1:0]  req0_tag,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [3:0]        req1_op,
  input  logic [31:0]       req1_a,
  input  logic [31:0]       req1_b,
  input  logic [TAG_W-1:0]  req1_tag,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [31:0]       rsp_result,
  output logic              rsp_id,
  output logic [TAG_W-1:0]  rsp_tag
`ifdef RV32I_ALU_ARB_STATS_EN
  ,
  output logic [STAT_W-1:0] stat_grant0,
  output logic [STAT_W-1:0] stat_grant1,
  output logic [STAT_W-1:0] stat_conflict
`endif
);

  logic              prio_r;
  logic              rsp_valid_r;
  logic [31:0]       rsp_result_r;
  logic              rsp_id_r;
  logic [TAG_W-1:0]  rsp_tag_r;
  logic              slot_free_s;
  logic              grant0_s;
  logic              grant1_s;
  logic              grant_any_s;
  logic [3:0]        alu_op_s;
  logic [31:0]       alu_a_s;
  logic [31:0]       alu_b_s;
  logic [TAG_W-1:0]  sel_tag_s;
  logic [31:0]       alu_result_s;

  // No grants while reset is asserted, even though the response slot reads empty
  assign slot_free_s = rst_n & (~rsp_valid_r | rsp_ready);

  // Round-robin grant: a lone requester wins, a tie goes to prio_r
  always_comb begin
    grant0_s = 1'b0;
    grant1_s = 1'b0;
    if (slot_free_s) begin
      if (req0_valid && (!req1_valid || !prio_r)) begin
        grant0_s = 1'b1;
      end else if (req1_valid) begin
        grant1_s = 1'b1;
      end else begin
        grant0_s = 1'b0;
      end
    end else begin
      grant1_s = 1'b0;
    end
  end

  assign grant_any_s = grant0_s | grant1_s;
  assign req0_ready  = grant0_s;
  assign req1_ready  = grant1_s;

  assign alu_op_s  = grant1_s ? req1_op  : req0_op;
  assign alu_a_s   = grant1_s ? req1_a   : req0_a;
  assign alu_b_s   = grant1_s ? req1_b   : req0_b;
  assign sel_tag_s = grant1_s ? req1_tag : req0_tag;

  rv32i_alu u_alu (
    .op     (alu_op_s),
    .a      (alu_a_s),
    .b      (alu_b_s),
    .result (alu_result_s)
  );

  // Response register and priority pointer; data holds its last value when not refilled
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prio_r       <= 1'b0;
      rsp_valid_r  <= 1'b0;
      rsp_result_r <= 32'd0;
      rsp_id_r     <= 1'b0;
      rsp_tag_r    <= '0;
    end else if (grant_any_s) begin
      prio_r       <= ~grant1_s;
      rsp_valid_r  <= 1'b1;
      rsp_result_r <= alu_result_s;
      rsp_id_r     <= grant1_s;
      rsp_tag_r    <= sel_tag_s;
    end else if (rsp_ready) begin
      rsp_valid_r  <= 1'b0;
    end
  end

  assign rsp_valid  = rsp_valid_r;
  assign rsp_result = rsp_result_r;
  assign rsp_id     = rsp_id_r;
  assign rsp_tag    = rsp_tag_r;

`ifdef RV32I_ALU_ARB_STATS_EN
  localparam logic [STAT_W-1:0] STAT_MAX = {STAT_W{1'b1}};
  localparam logic [STAT_W-1:0] STAT_ONE = {{(STAT_W-1){1'b0}}, 1'b1};

  logic [STAT_W-1:0] stat_grant0_r;
  logic [STAT_W-1:0] stat_grant1_r;
  logic [STAT_W-1:0] stat_conflict_r;

  // Saturating event counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_grant0_r   <= '0;
      stat_grant1_r   <= '0;
      stat_conflict_r <= '0;
    end else begin
      if (grant0_s && (stat_grant0_r != STAT_MAX)) begin
        stat_grant0_r <= stat_grant0_r + STAT_ONE;
      end
      if (grant1_s && (stat_grant1_r != STAT_MAX)) begin
        stat_grant1_r <= stat_grant1_r + STAT_ONE;
      end
      if (req0_valid && req1_valid && grant_any_s && (stat_conflict_r != STAT_MAX)) begin
        stat_conflict_r <= stat_conflict_r + STAT_ONE;
      end
    end
  end

  assign stat_grant0   = stat_grant0_r;
  assign stat_grant1   = stat_grant1_r;
  assign stat_conflict = stat_conflict_r;
`endif

endmodule
